// File: rtl/cpu_pkg.sv
// Shared widths, reset vector and the fetch buffer entry type used by the fetch stage.
package cpu_pkg;

    localparam int WORD_WIDTH = 16;
    localparam int ADDR_WIDTH = 16;

    // Address 0 holds the ROM default/nop, so execution starts one word in.
    localparam logic [ADDR_WIDTH-1:0] RESET_VECTOR_DEFAULT = 16'h0001;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] pc;
        logic [WORD_WIDTH-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Generic synchronous FIFO with occupancy count, flush, and same-cycle push/pop
// (a push into a full FIFO is accepted when a pop happens in the same cycle).
module fetch_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             srst,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] wr_data,
    output logic [WIDTH-1:0] rd_data,
    output logic             valid,
    output logic             full,
    output logic [PTR_W:0]   count
);

    localparam logic [PTR_W:0] DEPTH_C = (PTR_W+1)'(DEPTH);

    logic [WIDTH-1:0] mem_reg [DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [PTR_W:0]   count_reg;
    logic             pop_eff;
    logic             push_eff;

    assign pop_eff  = pop && (count_reg != '0);
    assign push_eff = push && !flush && ((count_reg != DEPTH_C) || pop_eff);

    always_ff @(posedge clk) begin
        if (srst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else if (flush) begin
            // A pop in the flush cycle is already complete; everything else is dropped.
            rd_ptr_reg <= wr_ptr_reg;
            count_reg  <= '0;
        end else begin
            if (push_eff) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop_eff)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
            unique case ({push_eff, pop_eff})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    // Entries are cleared on reset so the head reads zero until the first push.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : mem_gen
        always_ff @(posedge clk) begin
            if (srst) begin
                mem_reg[gi] <= '0;
            end else if (push_eff && (wr_ptr_reg == PTR_W'(gi))) begin
                mem_reg[gi] <= wr_data;
            end
        end
    end

    assign rd_data = mem_reg[rd_ptr_reg];
    assign valid   = (count_reg != '0);
    assign full    = (count_reg == DEPTH_C);
    assign count   = count_reg;

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: owns the PC, drives the combinational ROM, buffers {PC, word}
// pairs for decode, and flushes/restarts on execute redirects.
module instruction_fetch
    import cpu_pkg::*;
#(
    parameter logic [15:0] RESET_VECTOR = RESET_VECTOR_DEFAULT,
    parameter int          DEPTH        = 2
) (
    input  logic                     clk,
    input  logic                     sync_rst,
    input  logic                     FetchEnable,
    output logic [15:0]              InstructionAddress,
    input  logic [15:0]              InstructionIn,
    input  logic                     RedirectValid,
    input  logic [15:0]              RedirectAddress,
    output logic                     FetchValid,
    input  logic                     DecodeReady,
    output logic [15:0]              FetchInstruction,
    output logic [15:0]              FetchPC,
    output logic [$clog2(DEPTH):0]   BufferCount
);

    fetch_entry_t head_entry;
    fetch_entry_t tail_entry;
    logic [15:0]  pc_reg;
    logic [15:0]  pc_next;
    logic         pop;
    logic         push;
    logic         fifo_full;

    assign pop  = FetchValid && DecodeReady;
    // The redirect cycle never pushes: the word on the ROM bus belongs to the stale path.
    assign push = FetchEnable && !RedirectValid && (!fifo_full || pop);

    always_comb begin
        tail_entry       = '0;
        tail_entry.pc    = pc_reg;
        tail_entry.instr = InstructionIn;
    end

    always_comb begin
        pc_next = pc_reg;
        if (RedirectValid) begin
            pc_next = RedirectAddress;
        end else if (push) begin
            pc_next = pc_reg + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (sync_rst) begin
            pc_reg <= RESET_VECTOR;
        end else begin
            pc_reg <= pc_next;
        end
    end

    fetch_fifo #(
        .WIDTH ($bits(fetch_entry_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .srst    (sync_rst),
        .push    (push),
        .pop     (pop),
        .flush   (RedirectValid),
        .wr_data (tail_entry),
        .rd_data (head_entry),
        .valid   (FetchValid),
        .full    (fifo_full),
        .count   (BufferCount)
    );

    assign InstructionAddress = pc_reg;
    assign FetchInstruction   = head_entry.instr;
    assign FetchPC            = head_entry.pc;

endmodule
